reservoir_history_capture: RTL and testbench

Controlled capture engine between the reservoir output and the reservoir history RAM. It replaces the free-running sample counter with start/stop control, a programmable sample count, and single-shot or circular modes. It also adds decimation, multi-channel serialisation, and done/wrap/overrun status for the AXI config registers. It drives the write port of a single-port history RAM whose word width is DATA_WIDTH.

---
 rtl/reservoir_history_capture.sv | 257 +++++++++++++++++++++++++
 tb/tb_reservoir_history_capture.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservoir_history_capture.sv
// ---------------------------------------------------------------------------
// reservoir_history_capture
//
// Controlled capture engine sitting between the reservoir output and the
// write port of a single-port history RAM. A capture is armed with a start
// pulse and runs either single-shot (stops after num_samples samples) or
// circular (wraps the buffer until stopped). Inputs can be decimated, and
// each sample of NUM_CHANNELS words is serialised into consecutive RAM words.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start, stop   one-cycle control pulses
//   mode          0 = single-shot, 1 = circular (latched at start)
//   num_samples   samples per buffer (latched at start)
//   decim         keep 1 of every decim+1 valid inputs (latched at start)
//   din           NUM_CHANNELS words, channel 0 in the LSBs
//   din_valid     din holds a new reservoir sample
//   busy          capture in progress
//   done          one-cycle pulse when a capture ends
//   wrapped       sticky: circular buffer wrapped at least once
//   overrun       sticky: an accepted-candidate sample was dropped
//   head_ptr      index of the next sample slot to be written
//   ram_wen, ram_addr, ram_din   history RAM write port (registered)
//
// Handshake: din_valid is a one-cycle qualifier with no back-pressure; a
// candidate that arrives while the serialiser still has more than its final
// word to emit is dropped and flagged through overrun.
// ---------------------------------------------------------------------------
module reservoir_history_capture #(
    parameter int NUM_CHANNELS = 1,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 20,
    parameter int DECIM_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               mode,
    input  logic [ADDR_WIDTH-1:0]              num_samples,
    input  logic [DECIM_WIDTH-1:0]             decim,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] din,
    input  logic                               din_valid,
    output logic                               busy,
    output logic                               done,
    output logic                               wrapped,
    output logic                               overrun,
    output logic [ADDR_WIDTH-1:0]              head_ptr,
    output logic                               ram_wen,
    output logic [ADDR_WIDTH-1:0]              ram_addr,
    output logic [DATA_WIDTH-1:0]              ram_din
);

    localparam int SAMPLE_W = NUM_CHANNELS * DATA_WIDTH;
    // Counts words still to be launched after the current one; max NUM_CHANNELS-1.
    localparam int CNT_W    = $clog2(NUM_CHANNELS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]   ns_q, ns_d;
    logic [DECIM_WIDTH-1:0]  decim_q, decim_d;
    logic [DECIM_WIDTH-1:0]  dcnt_q, dcnt_d;
    logic [ADDR_WIDTH-1:0]   acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]   wp_q, wp_d;
    logic [ADDR_WIDTH-1:0]   head_q, head_d;
    logic [SAMPLE_W-1:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0]        left_q, left_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    wrapped_q, wrapped_d;
    logic                    overrun_q, overrun_d;
    logic                    ram_wen_q, ram_wen_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_din_q, ram_din_d;

    logic                    candidate;
    logic                    can_take;
    logic                    accept;
    logic                    launch;
    logic                    launch_last;
    logic [DATA_WIDTH-1:0]   launch_word;
    logic [ADDR_WIDTH-1:0]   ns_m1;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ns_d       = ns_q;
        decim_d    = decim_q;
        dcnt_d     = dcnt_q;
        acc_d      = acc_q;
        wp_d       = wp_q;
        head_d     = head_q;
        shadow_d   = shadow_q;
        left_d     = left_q;
        done_d     = 1'b0;
        wrapped_d  = wrapped_q;
        overrun_d  = overrun_q;
        ram_wen_d  = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;

        ns_m1       = ns_q - ADDR_WIDTH'(1);
        candidate   = (state_q == S_CAPTURE) && din_valid && (dcnt_q == decim_q);
        // left_q == 0 means the serialiser is empty or its output word this
        // cycle is the final channel, so a new sample can follow seamlessly.
        can_take    = (left_q == '0);
        accept      = candidate && !stop && can_take;
        launch      = 1'b0;
        launch_last = 1'b0;
        launch_word = '0;

        // Serialiser: an accepted sample emits channel 0 straight from din
        // and parks the rest in the shadow register, shifting one word out
        // per cycle.
        if (left_q != '0) begin
            launch      = 1'b1;
            launch_word = shadow_q[DATA_WIDTH-1:0];
            shadow_d    = shadow_q >> DATA_WIDTH;
            left_d      = left_q - CNT_W'(1);
            launch_last = (left_q == CNT_W'(1));
        end else if (accept) begin
            launch      = 1'b1;
            launch_word = din[DATA_WIDTH-1:0];
            shadow_d    = din >> DATA_WIDTH;
            left_d      = CNT_W'(NUM_CHANNELS - 1);
            launch_last = (NUM_CHANNELS == 1);
        end

        if (launch) begin
            ram_wen_d  = 1'b1;
            ram_addr_d = wp_q;
            ram_din_d  = launch_word;
            wp_d       = wp_q + ADDR_WIDTH'(1);
            if (launch_last) begin
                if (head_q == ns_m1) begin
                    head_d = '0;
                    if (mode_q) begin
                        wp_d      = '0;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    head_d = head_q + ADDR_WIDTH'(1);
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    ns_d      = num_samples;
                    decim_d   = decim;
                    head_d    = '0;
                    wp_d      = '0;
                    dcnt_d    = '0;
                    acc_d     = '0;
                    wrapped_d = 1'b0;
                    overrun_d = 1'b0;
                    if (num_samples == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (din_valid) begin
                    dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_WIDTH'(1);
                end
                if (candidate && !stop && !can_take) begin
                    overrun_d = 1'b1;
                end
                if (accept) begin
                    acc_d = acc_q + ADDR_WIDTH'(1);
                    if (!mode_q && (acc_q == ns_m1)) begin
                        state_d = S_DRAIN;
                    end
                end
                // With nothing left to launch, drain takes zero cycles and
                // done follows the final write immediately.
                if (stop) begin
                    if (left_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (left_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            ns_q       <= '0;
            decim_q    <= '0;
            dcnt_q     <= '0;
            acc_q      <= '0;
            wp_q       <= '0;
            head_q     <= '0;
            shadow_q   <= '0;
            left_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wrapped_q  <= 1'b0;
            overrun_q  <= 1'b0;
            ram_wen_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            ns_q       <= ns_d;
            decim_q    <= decim_d;
            dcnt_q     <= dcnt_d;
            acc_q      <= acc_d;
            wp_q       <= wp_d;
            head_q     <= head_d;
            shadow_q   <= shadow_d;
            left_q     <= left_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wrapped_q  <= wrapped_d;
            overrun_q  <= overrun_d;
            ram_wen_q  <= ram_wen_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wrapped  = wrapped_q;
    assign overrun  = overrun_q;
    assign head_ptr = head_q;
    assign ram_wen  = ram_wen_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_reservoir_history_capture.sv
// Directed bench: one single-channel instance and one three-channel instance
// share clock and reset. A negedge monitor logs RAM writes and done pulses.
module tb_reservoir_history_capture;

    localparam int AW = 20;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // single-channel instance
    logic          start1, stop1, mode1, dv1;
    logic [AW-1:0] ns1;
    logic [7:0]    dec1;
    logic [DW-1:0] din1;
    logic          busy1, done1, wrapped1, overrun1, wen1;
    logic [AW-1:0] head1, addr1;
    logic [DW-1:0] rdin1;

    // three-channel instance
    logic            start3, stop3, mode3, dv3;
    logic [AW-1:0]   ns3;
    logic [7:0]      dec3;
    logic [3*DW-1:0] din3;
    logic            busy3, done3, wrapped3, overrun3, wen3;
    logic [AW-1:0]   head3, addr3;
    logic [DW-1:0]   rdin3;

    reservoir_history_capture #(.NUM_CHANNELS(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1), .mode(mode1),
        .num_samples(ns1), .decim(dec1), .din(din1), .din_valid(dv1),
        .busy(busy1), .done(done1), .wrapped(wrapped1), .overrun(overrun1),
        .head_ptr(head1), .ram_wen(wen1), .ram_addr(addr1), .ram_din(rdin1)
    );

    reservoir_history_capture #(.NUM_CHANNELS(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .stop(stop3), .mode(mode3),
        .num_samples(ns3), .decim(dec3), .din(din3), .din_valid(dv3),
        .busy(busy3), .done(done3), .wrapped(wrapped3), .overrun(overrun3),
        .head_ptr(head3), .ram_wen(wen3), .ram_addr(addr3), .ram_din(rdin3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [AW+DW-1:0] wr1_q[$];
    logic [AW+DW-1:0] wr3_q[$];
    logic [AW+DW-1:0] exp_q[$];
    int done1_n = 0, done3_n = 0;
    int done1_cyc = 0, last_wr1_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wen1 === 1'b1) begin
            wr1_q.push_back({addr1, rdin1});
            last_wr1_cyc = cyc;
        end
        if (done1 === 1'b1) begin
            done1_n++;
            done1_cyc = cyc;
        end
        if (wen3 === 1'b1) wr3_q.push_back({addr3, rdin3});
        if (done3 === 1'b1) done3_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cap1(input logic m, input int ns, input int d);
        mode1 = m; ns1 = AW'(ns); dec1 = 8'(d); start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    task automatic start_cap3(input logic m, input int ns, input int d);
        mode3 = m; ns3 = AW'(ns); dec3 = 8'(d); start3 = 1'b1;
        tick();
        start3 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start1 = 0; stop1 = 0; mode1 = 0; ns1 = '0; dec1 = '0; din1 = '0; dv1 = 0;
        start3 = 0; stop3 = 0; mode3 = 0; ns3 = '0; dec3 = '0; din3 = '0; dv3 = 0;
        repeat (2) tick();
        n_cmp++;
        if ({busy1, done1, wrapped1, overrun1, head1, wen1, addr1, rdin1} !== '0) begin
            n_bad++;
            $display("FAIL reset_u1: got %0h expected 0",
                     {busy1, done1, wrapped1, overrun1, head1, wen1, addr1, rdin1});
        end
        n_cmp++;
        if ({busy3, done3, wrapped3, overrun3, head3, wen3, addr3, rdin3} !== '0) begin
            n_bad++;
            $display("FAIL reset_u3: got %0h expected 0",
                     {busy3, done3, wrapped3, overrun3, head3, wen3, addr3, rdin3});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_shot();
        int d0;
        logic [AW+DW-1:0] got;
        wr1_q.delete(); exp_q.delete(); d0 = done1_n;
        start_cap1(1'b0, 4, 0);
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_bad++; $display("FAIL single_busy_rise: got %b expected 1", busy1);
        end
        for (int i = 0; i < 6; i++) begin
            dv1 = 1'b1; din1 = DW'(10 + i);
            tick();
        end
        dv1 = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) exp_q.push_back({AW'(i), DW'(10 + i)});
        n_cmp++;
        if (wr1_q.size() !== 4) begin
            n_bad++; $display("FAIL single_count: got %0d expected 4", wr1_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr1_q.size()) ? wr1_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_bad++; $display("FAIL single_write%0d: got %0h expected %0h", i, got, exp_q[i]);
            end
        end
        n_cmp++;
        if (done1_n - d0 !== 1) begin
            n_bad++; $display("FAIL single_done_count: got %0d expected 1", done1_n - d0);
        end
        n_cmp++;
        if (done1_cyc !== last_wr1_cyc + 1) begin
            n_bad++; $display("FAIL single_done_timing: got %0d expected %0d", done1_cyc, last_wr1_cyc + 1);
        end
        n_cmp++;
        if ({busy1, wrapped1, overrun1} !== 3'b000) begin
            n_bad++; $display("FAIL single_status: got %b expected 000", {busy1, wrapped1, overrun1});
        end
    endtask

    task automatic test_decimation();
        int d0;
        logic [AW+DW-1:0] got;
        wr1_q.delete(); exp_q.delete(); d0 = done1_n;
        start_cap1(1'b0, 3, 2);
        for (int i = 1; i <= 12; i++) begin
            dv1 = 1'b1; din1 = DW'(i);
            tick();
        end
        dv1 = 1'b0;
        repeat (4) tick();
        exp_q.push_back({AW'(0), DW'(3)});
        exp_q.push_back({AW'(1), DW'(6)});
        exp_q.push_back({AW'(2), DW'(9)});
        n_cmp++;
        if (wr1_q.size() !== 3) begin
            n_bad++; $display("FAIL decim_count: got %0d expected 3", wr1_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr1_q.size()) ? wr1_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_bad++; $display("FAIL decim_write%0d: got %0h expected %0h", i, got, exp_q[i]);
            end
        end
        n_cmp++;
        if (done1_n - d0 !== 1 || overrun1 !== 1'b0) begin
            n_bad++; $display("FAIL decim_done_overrun: got done=%0d ovr=%b expected done=1 ovr=0",
                              done1_n - d0, overrun1);
        end
    endtask

    task automatic test_circular();
        int d0;
        logic [AW+DW-1:0] got;
        wr1_q.delete(); exp_q.delete(); d0 = done1_n;
        start_cap1(1'b1, 4, 0);
        for (int i = 0; i < 10; i++) begin
            dv1 = 1'b1; din1 = DW'(100 + i);
            tick();
        end
        dv1 = 1'b0; stop1 = 1'b1;
        tick();
        stop1 = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 10; i++) exp_q.push_back({AW'(i % 4), DW'(100 + i)});
        n_cmp++;
        if (wr1_q.size() !== 10) begin
            n_bad++; $display("FAIL circ_count: got %0d expected 10", wr1_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr1_q.size()) ? wr1_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_bad++; $display("FAIL circ_write%0d: got %0h expected %0h", i, got, exp_q[i]);
            end
        end
        n_cmp++;
        if (wrapped1 !== 1'b1) begin
            n_bad++; $display("FAIL circ_wrapped: got %b expected 1", wrapped1);
        end
        n_cmp++;
        if (head1 !== AW'(2)) begin
            n_bad++; $display("FAIL circ_head: got %0d expected 2", head1);
        end
        n_cmp++;
        if (done1_n - d0 !== 1) begin
            n_bad++; $display("FAIL circ_done_count: got %0d expected 1", done1_n - d0);
        end
        n_cmp++;
        if (done1_cyc !== last_wr1_cyc + 1) begin
            n_bad++; $display("FAIL circ_done_timing: got %0d expected %0d", done1_cyc, last_wr1_cyc + 1);
        end
        n_cmp++;
        if (busy1 !== 1'b0 || overrun1 !== 1'b0) begin
            n_bad++; $display("FAIL circ_status: got busy=%b ovr=%b expected 0 0", busy1, overrun1);
        end
    endtask

    function automatic logic [3*DW-1:0] pack3(input int k);
        return {DW'(k * 16 + 3), DW'(k * 16 + 2), DW'(k * 16 + 1)};
    endfunction

    task automatic test_overrun();
        int d0;
        logic [AW+DW-1:0] got;
        wr3_q.delete(); exp_q.delete(); d0 = done3_n;
        start_cap3(1'b0, 4, 0);
        // inputs on cycles 0,1 and 3; cycle 3 is the 1st sample's last-channel cycle
        dv3 = 1'b1; din3 = pack3(1); tick();
        dv3 = 1'b1; din3 = pack3(2); tick();
        dv3 = 1'b0; din3 = '0;       tick();
        dv3 = 1'b1; din3 = pack3(3); tick();
        dv3 = 1'b0;
        repeat (4) tick();
        stop3 = 1'b1; tick(); stop3 = 1'b0;
        repeat (3) tick();
        for (int j = 0; j < 3; j++) exp_q.push_back({AW'(j),     DW'(16 + j + 1)});
        for (int j = 0; j < 3; j++) exp_q.push_back({AW'(3 + j), DW'(48 + j + 1)});
        n_cmp++;
        if (wr3_q.size() !== 6) begin
            n_bad++; $display("FAIL ovr_count: got %0d expected 6", wr3_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr3_q.size()) ? wr3_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_bad++; $display("FAIL ovr_write%0d: got %0h expected %0h", i, got, exp_q[i]);
            end
        end
        n_cmp++;
        if (overrun3 !== 1'b1) begin
            n_bad++; $display("FAIL ovr_flag: got %b expected 1", overrun3);
        end
        n_cmp++;
        if (head3 !== AW'(2) || done3_n - d0 !== 1 || wrapped3 !== 1'b0) begin
            n_bad++; $display("FAIL ovr_status: got head=%0d done=%0d wrap=%b expected 2 1 0",
                              head3, done3_n - d0, wrapped3);
        end
    endtask

    task automatic test_edge_controls();
        int d0;
        logic [AW+DW-1:0] got;
        // num_samples = 0
        wr1_q.delete(); d0 = done1_n;
        mode1 = 1'b0; ns1 = '0; dec1 = '0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n_cmp++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            n_bad++; $display("FAIL zero_ns_pulse: got done=%b busy=%b expected 1 0", done1, busy1);
        end
        tick();
        n_cmp++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || wr1_q.size() !== 0) begin
            n_bad++; $display("FAIL zero_ns_after: got done=%b busy=%b writes=%0d expected 0 0 0",
                              done1, busy1, wr1_q.size());
        end

        // start while busy is ignored
        wr1_q.delete(); exp_q.delete();
        start_cap1(1'b1, 4, 0);
        for (int i = 0; i < 6; i++) begin
            dv1 = 1'b1; din1 = DW'(200 + i);
            if (i == 2) begin
                mode1 = 1'b0; ns1 = AW'(1); dec1 = 8'd5; start1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            tick();
        end
        start1 = 1'b0; dv1 = 1'b0; stop1 = 1'b1;
        tick();
        stop1 = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) exp_q.push_back({AW'(i % 4), DW'(200 + i)});
        n_cmp++;
        if (wr1_q.size() !== 6) begin
            n_bad++; $display("FAIL busy_start_count: got %0d expected 6", wr1_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr1_q.size()) ? wr1_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_bad++; $display("FAIL busy_start_write%0d: got %0h expected %0h", i, got, exp_q[i]);
            end
        end
        n_cmp++;
        if (head1 !== AW'(2) || wrapped1 !== 1'b1) begin
            n_bad++; $display("FAIL busy_start_status: got head=%0d wrap=%b expected 2 1", head1, wrapped1);
        end

        // asynchronous reset mid-capture
        d0 = done1_n;
        start_cap1(1'b0, 8, 0);
        for (int i = 0; i < 3; i++) begin
            dv1 = 1'b1; din1 = DW'(300 + i);
            tick();
        end
        n_cmp++;
        if (busy1 !== 1'b1 || wen1 !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre: got busy=%b wen=%b expected 1 1", busy1, wen1);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy1, done1, wrapped1, overrun1, head1, wen1, addr1, rdin1} !== '0) begin
            n_bad++; $display("FAIL rst_async: got %0h expected 0",
                              {busy1, done1, wrapped1, overrun1, head1, wen1, addr1, rdin1});
        end
        dv1 = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (done1_n - d0 !== 0 || busy1 !== 1'b0) begin
            n_bad++; $display("FAIL rst_no_done: got done=%0d busy=%b expected 0 0", done1_n - d0, busy1);
        end

        // a new start clears the sticky overrun left by the earlier capture
        start3 = 1'b0;
        d0 = done3_n;
        start_cap3(1'b0, 2, 0);
        n_cmp++;
        if (overrun3 !== 1'b0 || busy3 !== 1'b1) begin
            n_bad++; $display("FAIL restart_clear: got ovr=%b busy=%b expected 0 1", overrun3, busy3);
        end
        stop3 = 1'b1; tick(); stop3 = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (done3_n - d0 !== 1 || busy3 !== 1'b0) begin
            n_bad++; $display("FAIL restart_stop: got done=%0d busy=%b expected 1 0", done3_n - d0, busy3);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_decimation();
        test_circular();
        test_overrun();
        test_edge_controls();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
